// File: rtl/seq_serial_rx.sv
// seq_serial_rx: oversampling serial frame receiver (start/data/[parity]/stop) feeding a valid/ready output register.
// Define SEQ_SERIAL_RX_PARITY_EN to compile in the even-parity bit after the data bits.
module seq_serial_rx #(
    parameter int DIV    = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic              ready,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SEQ_SERIAL_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              done_q, done_d;
    logic              stop_q, stop_d;
    logic [1:0]        sync_q;
    logic              rx_s;
    logic              load;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], rx_in};
    end

`ifdef SEQ_SERIAL_RX_PARITY_EN
    logic par_q, par_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            done_q  <= 1'b0;
            stop_q  <= 1'b0;
`ifdef SEQ_SERIAL_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
            stop_q  <= stop_d;
`ifdef SEQ_SERIAL_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        stop_d  = stop_q;
`ifdef SEQ_SERIAL_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Half a bit in: a line that is high again was only a glitch.
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    if (rx_s) state_d = IDLE;
                    else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end else cnt_d = cnt_q + CNT_W'(1);
            end
            DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx_s;
                    if (idx_q == LAST_IDX) begin
`ifdef SEQ_SERIAL_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else idx_d = idx_q + IDX_W'(1);
                end else cnt_d = cnt_q + CNT_W'(1);
            end
`ifdef SEQ_SERIAL_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    par_d   = (^shreg_q) ^ rx_s;
                    state_d = STOP;
                end else cnt_d = cnt_q + CNT_W'(1);
            end
`endif
            STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    stop_d  = rx_s;
                    state_d = rx_s ? IDLE : BREAK;
                end else cnt_d = cnt_q + CNT_W'(1);
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // shreg_q stays stable for a full bit after the stop sample, so the output stage reads it one edge later.
    assign load = done_q && (!valid || ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= done_q && valid && !ready;
            if (valid && ready) valid <= 1'b0;
            if (load) begin
                data_out  <= shreg_q;
                frame_err <= !stop_q;
                valid     <= 1'b1;
            end
        end
    end

`ifdef SEQ_SERIAL_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       parity_err <= 1'b0;
        else if (load) parity_err <= par_q;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
